// File: rtl/cac_decoder_9_if.sv
// Handshake bundle between the bus capture stage, the FNS decoder and its consumer.
// The slave modport is the decoder's view; the master modport is the surrounding logic's view.
interface cac_decoder_9_if #(
  parameter int CODE_W = 9,
  parameter int SUM_W  = 7
);
  logic [CODE_W-1:0] code_in;
  logic              in_valid;
  logic              in_ready;
  logic [SUM_W-1:0]  data_out;
  logic              range_err;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  code_in, in_valid, out_ready,
    output in_ready, data_out, range_err, out_valid
  );

  modport master (
    output code_in, in_valid, out_ready,
    input  in_ready, data_out, range_err, out_valid
  );
endinterface

// File: rtl/cac_decoder_9.sv
// Serial Fibonacci-numeral-system decoder: one codeword bit per clock, LSB first,
// with a range flag for values that no valid crosstalk-avoidance codeword can produce.
module cac_decoder_9 #(
  parameter int CODE_W = 9,
  parameter int SUM_W  = 7
) (
  input  logic        clock,
  input  logic        reset,
  cac_decoder_9_if.slave bus,
  output logic [1:0]  dbg_state_o
);
  // Handshake: a transfer happens on any rising edge where valid and ready are both 1.
  // in_ready depends only on state; out_valid, once raised, stays until out_ready is seen.

  localparam int CNT_W = $clog2(CODE_W + 1);

  function automatic int fib(input int n);
    int a;
    int b;
    int t;
    a = 1;
    b = 1;
    for (int i = 2; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  localparam logic [SUM_W-1:0] LIMIT = SUM_W'(fib(CODE_W + 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [SUM_W-1:0]  w_q, w_d;
  logic [SUM_W-1:0]  wn_q, wn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  data_q, data_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      w_q     <= '0;
      wn_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      wn_q    <= wn_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    w_d     = w_q;
    wn_d    = wn_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shift_d = bus.code_in;
          acc_d   = '0;
          w_d     = SUM_W'(1);
          wn_d    = SUM_W'(1);
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        // Once every bit has been weighted, the extra cycle publishes the sum.
        if (cnt_q == CNT_W'(CODE_W)) begin
          data_d  = acc_q;
          err_d   = (acc_q >= LIMIT);
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          if (shift_q[0]) begin
            acc_d = acc_q + w_q;
          end
          shift_d = shift_q >> 1;
          w_d     = wn_q;
          wn_d    = w_q + wn_q;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = valid_q;
  assign bus.data_out  = data_q;
  assign bus.range_err = err_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_cac_decoder_9.sv
// Self-checking bench for cac_decoder_9: directed decodes, backpressure, reset abort,
// and a randomized stream compared against a Fibonacci-sum reference model.
module tb_cac_decoder_9;
  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;
  int errors;
  int checks;
  logic [6:0] exp_q[$];
  logic       exp_err_q[$];

  cac_decoder_9_if #(.CODE_W(9), .SUM_W(7)) bus ();

  cac_decoder_9 dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: value = sum of F(i+1) over set bits, F(1)=F(2)=1.
  function automatic int ref_value(input logic [8:0] code);
    int f[9];
    int sum;
    f[0] = 1;
    f[1] = 1;
    for (int i = 2; i < 9; i++) f[i] = f[i-1] + f[i-2];
    sum = 0;
    for (int i = 0; i < 9; i++) if (code[i]) sum += f[i];
    return sum;
  endfunction

  task automatic send(input logic [8:0] code, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      bus.code_in  = code;
      bus.in_valid = 1'b1;
      @(posedge clock);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clock);
      cycles++;
      @(negedge clock);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++;
    if (bus.data_out !== 7'd0) begin errors++; $display("FAIL reset_data_out got=%0d want=0", bus.data_out); end
    checks++;
    if (bus.range_err !== 1'b0) begin errors++; $display("FAIL reset_range_err got=%b want=0", bus.range_err); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    reset = 1'b0;
  endtask

  task automatic test_zero_latency();
    bit ok;
    int cyc;
    send(9'b000000000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_send got=timeout want=accepted"); end
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready_acc got=%b want=0", bus.in_ready); end
    wait_valid(cyc, ok);
    checks++;
    if (!ok || cyc != 10) begin errors++; $display("FAIL zero_latency got=%0d ok=%0d want=10", cyc, ok); end
    checks++;
    if (bus.data_out !== 7'd0 || bus.range_err !== 1'b0) begin
      errors++; $display("FAIL zero_result got=%0d/%b want=0/0", bus.data_out, bus.range_err);
    end
    accept();
  endtask

  task automatic test_decode_table();
    logic [8:0] codes[6];
    logic [6:0] vals[6];
    logic       errs[6];
    bit ok;
    int cyc;
    codes = '{9'b101010100, 9'b000000011, 9'b000000010, 9'b000000001, 9'b111111111, 9'b110000000};
    vals  = '{7'd54, 7'd2, 7'd1, 7'd1, 7'd88, 7'd55};
    errs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      send(codes[i], ok);
      wait_valid(cyc, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL decode_timeout code=%b got=no_valid want=valid", codes[i]);
      end else if (bus.data_out !== vals[i] || bus.range_err !== errs[i]) begin
        errors++;
        $display("FAIL decode code=%b got=%0d/%b want=%0d/%b", codes[i], bus.data_out, bus.range_err, vals[i], errs[i]);
      end
      accept();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    send(9'b010010001, ok);
    wait_valid(cyc, ok);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== 7'd27 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d got=v%b d%0d r%b want=v1 d27 r0", i, bus.out_valid, bus.data_out, bus.in_ready);
      end
      @(negedge clock);
    end
    accept();
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL backpressure_release got=v%b r%b want=v0 r1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    send(9'b101010100, ok);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.data_out !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid got=v%b r%b d%0d want=v0 r1 d0", bus.out_valid, bus.in_ready, bus.data_out);
    end
    @(negedge clock);
    reset = 1'b0;
    send(9'b000100000, ok);
    wait_valid(cyc, ok);
    checks++;
    if (!ok || bus.data_out !== 7'd8 || bus.range_err !== 1'b0) begin
      errors++; $display("FAIL reset_mid_next got=%0d/%b ok=%0d want=8/0", bus.data_out, bus.range_err, ok);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    int received;
    received = 0;
    fork
      begin
        bit ok;
        logic [8:0] code;
        int v;
        for (int i = 0; i < 20; i++) begin
          code = 9'($urandom_range(0, 511));
          send(code, ok);
          v = ref_value(code);
          if (ok) begin
            exp_q.push_back(7'(v));
            exp_err_q.push_back(v >= 55);
          end else begin
            checks++; errors++; $display("FAIL stream_send idx=%0d got=timeout want=accepted", i);
          end
        end
      end
      begin
        logic [6:0] e;
        logic       ee;
        for (int n = 0; n < 2000 && received < 20; n++) begin
          @(negedge clock);
          bus.out_ready = 1'($urandom_range(0, 1));
          if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL stream_extra got=%0d want=none", bus.data_out);
            end else begin
              e = exp_q.pop_front();
              ee = exp_err_q.pop_front();
              if (bus.data_out !== e || bus.range_err !== ee) begin
                errors++;
                $display("FAIL stream idx=%0d got=%0d/%b want=%0d/%b", received, bus.data_out, bus.range_err, e, ee);
              end
            end
            received++;
          end
        end
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
      end
    join
    checks++;
    if (received != 20 || exp_q.size() != 0) begin
      errors++; $display("FAIL stream_count got=%0d left=%0d want=20 left=0", received, exp_q.size());
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.code_in = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_zero_latency();
    test_decode_table();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
